dmem_port_arbiter: RTL and testbench

//  Shares the single synchronous data-memory port between the pipeline MEM stage (core) and an

---
 rtl/dmem_port_arbiter_pkg.sv | 29 ++
 rtl/dmem_port_arbiter_if.sv | 47 ++++
 rtl/dmem_port_arbiter_age_counter.sv | 32 +++
 rtl/dmem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and widths for the data-memory port arbiter.
// The DMEM_ARB_PERF_EN build macro only affects the top module; nothing here depends on it.
package dmem_port_arbiter_pkg;

  localparam int DATA_W     = 32;
  localparam int DM_ADDRESS = 9;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CORE,
    ARB_EXT,
    ARB_EXT_LOCK
  } arb_state_t;

  // One memory access. The same layout is used for the core side, the ext side and the memory side.
  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [2:0]            func3;
  } mem_req_t;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundles the core request, the ext requester and the datamemory port into one interface.
// slave: the arbiter's view. master: the view of the core, the ext requester and the memory.
interface dmem_port_arbiter_if;
  import dmem_port_arbiter_pkg::*;

  // core (MEM stage)
  logic                  core_rd;
  logic                  core_wr;
  logic [DM_ADDRESS-1:0] core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [2:0]            core_func3;
  logic                  core_stall;
  // ext requester
  logic                  ext_valid;
  logic                  ext_we;
  logic                  ext_lock;
  logic [DM_ADDRESS-1:0] ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic [2:0]            ext_func3;
  logic                  ext_ready;
  logic                  ext_rvalid;
  logic [DATA_W-1:0]     ext_rdata;
  // datamemory
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata, core_func3,
    input  ext_valid, ext_we, ext_lock, ext_addr, ext_wdata, ext_func3,
    input  mem_rdata,
    output core_stall, ext_ready, ext_rvalid, ext_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata, core_func3,
    output ext_valid, ext_we, ext_lock, ext_addr, ext_wdata, ext_func3,
    output mem_rdata,
    input  core_stall, ext_ready, ext_rvalid, ext_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3
  );

endinterface

// File: rtl/dmem_port_arbiter_age_counter.sv
// Saturating up-counter with clear. o_sat is high once the count has reached LIMIT.
// Used for both the ext starvation age and the locked-burst beat count.
module arb_age_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int W     = cnt_w(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  logic [W-1:0] r_count;

  assign o_sat = (r_count >= W'(LIMIT));

  // Count up to LIMIT and hold there; clear has priority over increment.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single datamemory port between the MEM-stage core access and an ext requester.
// Core has priority; ext wins when the core is idle, when its request has aged STARVE_LIM cycles,
// or for up to MAX_BURST beats while it holds ext_lock.
// Build macro DMEM_ARB_PERF_EN adds saturating perf counters for core stalls and ext grants.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_port_arbiter_if.slave    bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_core_stalls,
  output logic [31:0]           perf_ext_grants
`endif
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_core_req;
  logic              w_ext_grant;
  logic              w_age_sat;
  logic              w_beat_sat;
  logic              w_beat_inc;
  logic              w_beat_clr;
  logic              r_rsp_ext;
  logic [DATA_W-1:0] r_rdata_hold;
  mem_req_t          w_core_side;
  mem_req_t          w_ext_side;
  mem_req_t          w_mem_side;

  assign w_core_req = bus.core_rd | bus.core_wr;

  // Pack both requesters into the common request shape; a core write suppresses a core read.
  always_comb begin
    w_core_side = '{rd: bus.core_rd & ~bus.core_wr, wr: bus.core_wr, addr: bus.core_addr,
                    wdata: bus.core_wdata, func3: bus.core_func3};
    w_ext_side  = '{rd: ~bus.ext_we, wr: bus.ext_we, addr: bus.ext_addr,
                    wdata: bus.ext_wdata, func3: bus.ext_func3};
  end

  // Grant decision and next state; the lock state keeps ext regardless of core or age.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ext_grant = 1'b0;
    w_state_nxt = ARB_IDLE;
    if (r_state == ARB_EXT_LOCK) begin
      w_ext_grant = bus.ext_valid;
    end else begin
      w_ext_grant = bus.ext_valid && (!w_core_req || w_age_sat);
    end
    if (w_ext_grant) begin
      w_state_nxt = (bus.ext_lock && !w_beat_sat) ? ARB_EXT_LOCK : ARB_EXT;
    end else if (r_state == ARB_EXT_LOCK) begin
      w_state_nxt = ARB_IDLE;
    end else if (w_core_req) begin
      w_state_nxt = ARB_CORE;
    end
  end

  // Beat counts every grant that keeps (or puts) the arbiter in the locked state.
  assign w_beat_inc = w_ext_grant && (w_state_nxt == ARB_EXT_LOCK);
  assign w_beat_clr = (w_state_nxt != ARB_EXT_LOCK);

  arb_age_counter #(.LIMIT(STARVE_LIM)) u_age (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (bus.ext_valid && !w_ext_grant),
    .i_clr (w_ext_grant),
    .o_sat (w_age_sat)
  );

  arb_age_counter #(.LIMIT(MAX_BURST - 1)) u_beat (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (w_beat_inc),
    .i_clr (w_beat_clr),
    .o_sat (w_beat_sat)
  );

  // Arbitration state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Track whether next cycle's mem_rdata belongs to ext, and keep the last ext read word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_ext    <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      r_rsp_ext <= w_ext_grant && !bus.ext_we;
      if (r_rsp_ext) begin
        r_rdata_hold <= bus.mem_rdata;
      end
    end
  end

  assign w_mem_side     = w_ext_grant ? w_ext_side : w_core_side;
  assign bus.mem_rd     = w_mem_side.rd;
  assign bus.mem_wr     = w_mem_side.wr;
  assign bus.mem_addr   = w_mem_side.addr;
  assign bus.mem_wdata  = w_mem_side.wdata;
  assign bus.mem_func3  = w_mem_side.func3;
  assign bus.core_stall = w_ext_grant && w_core_req;
  assign bus.ext_ready  = w_ext_grant;
  assign bus.ext_rvalid = r_rsp_ext;
  assign bus.ext_rdata  = r_rsp_ext ? bus.mem_rdata : r_rdata_hold;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_core_stalls;
  logic [31:0] r_perf_ext_grants;

  // Saturating event counters for core stall cycles and ext grant cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_core_stalls <= '0;
      r_perf_ext_grants  <= '0;
    end else begin
      if (w_ext_grant && w_core_req && (r_perf_core_stalls != '1)) begin
        r_perf_core_stalls <= r_perf_core_stalls + 1'b1;
      end
      if (w_ext_grant && (r_perf_ext_grants != '1)) begin
        r_perf_ext_grants <= r_perf_ext_grants + 1'b1;
      end
    end
  end

  assign perf_core_stalls = r_perf_core_stalls;
  assign perf_ext_grants  = r_perf_ext_grants;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a table of single-cycle vectors plus hand-written
// sequences for read latency, starvation, locked bursts and asynchronous reset.
module tb_dmem_port_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  dmem_port_arbiter_if u_if ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_core_stalls;
  logic [31:0] perf_ext_grants;
`endif

  dmem_port_arbiter #(.STARVE_LIM(4), .MAX_BURST(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_core_stalls (perf_core_stalls),
    .perf_ext_grants  (perf_ext_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: write on the edge, read data valid the cycle after mem_rd.
  logic [31:0] mem_model [512];
  always_ff @(posedge clk) begin
    if (u_if.mem_wr) mem_model[u_if.mem_addr] <= u_if.mem_wdata;
    if (u_if.mem_rd) u_if.mem_rdata <= mem_model[u_if.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    u_if.core_rd    = 1'b0;
    u_if.core_wr    = 1'b0;
    u_if.core_addr  = '0;
    u_if.core_wdata = '0;
    u_if.core_func3 = 3'b010;
    u_if.ext_valid  = 1'b0;
    u_if.ext_we     = 1'b0;
    u_if.ext_lock   = 1'b0;
    u_if.ext_addr   = '0;
    u_if.ext_wdata  = '0;
    u_if.ext_func3  = 3'b010;
  endtask

  typedef struct {
    string      name;
    logic       core_rd;
    logic       core_wr;
    logic       ext_valid;
    logic       ext_we;
    logic       ext_lock;
    logic [8:0] core_addr;
    logic [8:0] ext_addr;
    logic       exp_mem_rd;
    logic       exp_mem_wr;
    logic [8:0] exp_mem_addr;
    logic       exp_stall;
    logic       exp_ready;
  } vec_t;

  vec_t vecs [10];
  int   beat;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stalls_before;
  logic [31:0] grants_before;
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //          name         crd  cwr  ev   ewe  elk  caddr  eaddr  mrd  mwr  maddr  stl  rdy
    vecs[0] = '{"idle",       0,   0,   0,   0,   0,  9'h00, 9'h00,  0,   0,  9'h00,  0,   0};
    vecs[1] = '{"core_rd_a",  1,   0,   0,   0,   0,  9'h10, 9'h00,  1,   0,  9'h10,  0,   0};
    vecs[2] = '{"core_rd_b",  1,   0,   0,   0,   0,  9'h10, 9'h00,  1,   0,  9'h10,  0,   0};
    vecs[3] = '{"core_wr",    0,   1,   0,   0,   0,  9'h14, 9'h00,  0,   1,  9'h14,  0,   0};
    vecs[4] = '{"core_rdwr",  1,   1,   0,   0,   0,  9'h18, 9'h00,  0,   1,  9'h18,  0,   0};
    vecs[5] = '{"ext_wr",     0,   0,   1,   1,   0,  9'h00, 9'h30,  0,   1,  9'h30,  0,   1};
    vecs[6] = '{"ext_rd_lk",  0,   0,   1,   0,   1,  9'h00, 9'h34,  1,   0,  9'h34,  0,   1};
    vecs[7] = '{"lock_drop",  0,   1,   0,   0,   1,  9'h38, 9'h00,  0,   1,  9'h38,  0,   0};
    vecs[8] = '{"contend0",   1,   0,   1,   1,   0,  9'h3C, 9'h3E,  1,   0,  9'h3C,  0,   0};
    vecs[9] = '{"ext_clear",  0,   0,   1,   1,   0,  9'h00, 9'h40,  0,   1,  9'h40,  0,   1};

    // Reset state.
    reset = 1'b0;
    drive_idle();
    #1;
    check("rst_rvalid", 32'(u_if.ext_rvalid), 32'd0);
    check("rst_rdata",  u_if.ext_rdata,       32'd0);
    check("rst_ready",  32'(u_if.ext_ready),  32'd0);
    check("rst_stall",  32'(u_if.core_stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_idle();
      u_if.core_rd   = vecs[i].core_rd;
      u_if.core_wr   = vecs[i].core_wr;
      u_if.core_addr = vecs[i].core_addr;
      u_if.ext_valid = vecs[i].ext_valid;
      u_if.ext_we    = vecs[i].ext_we;
      u_if.ext_lock  = vecs[i].ext_lock;
      u_if.ext_addr  = vecs[i].ext_addr;
      u_if.ext_wdata = 32'h5A00_0000 | 32'(i);
      #1;
      check({vecs[i].name, ".mem_rd"},   32'(u_if.mem_rd),     32'(vecs[i].exp_mem_rd));
      check({vecs[i].name, ".mem_wr"},   32'(u_if.mem_wr),     32'(vecs[i].exp_mem_wr));
      check({vecs[i].name, ".mem_addr"}, 32'(u_if.mem_addr),   32'(vecs[i].exp_mem_addr));
      check({vecs[i].name, ".stall"},    32'(u_if.core_stall), 32'(vecs[i].exp_stall));
      check({vecs[i].name, ".ready"},    32'(u_if.ext_ready),  32'(vecs[i].exp_ready));
    end

    // Ext write then ext read of 0xDEADBEEF; read data one cycle after the grant.
    @(negedge clk);
    drive_idle();
    u_if.ext_valid = 1'b1;
    u_if.ext_we    = 1'b1;
    u_if.ext_addr  = 9'h20;
    u_if.ext_wdata = 32'hDEAD_BEEF;
    u_if.ext_func3 = 3'b010;
    #1;
    check("extwr.ready", 32'(u_if.ext_ready), 32'd1);
    check("extwr.wdata", u_if.mem_wdata,      32'hDEAD_BEEF);
    check("extwr.func3", 32'(u_if.mem_func3), 32'd2);
    @(negedge clk);
    u_if.ext_we = 1'b0;
    #1;
    check("extrd.ready",  32'(u_if.ext_ready), 32'd1);
    check("extrd.mem_rd", 32'(u_if.mem_rd),    32'd1);
    check("extrd.addr",   32'(u_if.mem_addr),  32'h20);
    @(negedge clk);
    drive_idle();
    #1;
    check("extrd.rvalid", 32'(u_if.ext_rvalid), 32'd1);
    check("extrd.rdata",  u_if.ext_rdata,       32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    check("extrd.rvalid_off", 32'(u_if.ext_rvalid), 32'd0);
    check("extrd.rdata_hold", u_if.ext_rdata,       32'hDEAD_BEEF);

    // Starvation: core wins four cycles, ext the fifth, core again the sixth.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive_idle();
      u_if.core_rd   = 1'b1;
      u_if.core_addr = 9'h10;
      u_if.ext_valid = 1'b1;
      u_if.ext_we    = 1'b1;
      u_if.ext_addr  = 9'h44;
      u_if.ext_wdata = 32'h0000_0044;
      #1;
`ifdef DMEM_ARB_PERF_EN
      if (c == 0) begin
        stalls_before = perf_core_stalls;
        grants_before = perf_ext_grants;
      end
`endif
      check($sformatf("starve%0d.ready", c), 32'(u_if.ext_ready),  32'(c == 4));
      check($sformatf("starve%0d.stall", c), 32'(u_if.core_stall), 32'(c == 4));
      check($sformatf("starve%0d.addr", c),  32'(u_if.mem_addr),   (c == 4) ? 32'h44 : 32'h10);
    end
    // Ext alone is granted immediately, which also clears the age left by the last cycle.
    @(negedge clk);
    drive_idle();
    u_if.ext_valid = 1'b1;
    u_if.ext_we    = 1'b1;
    u_if.ext_addr  = 9'h48;
    #1;
`ifdef DMEM_ARB_PERF_EN
    check("perf.core_stalls", perf_core_stalls - stalls_before, 32'd1);
    check("perf.ext_grants",  perf_ext_grants - grants_before,  32'd1);
`endif
    check("ext_alone.ready", 32'(u_if.ext_ready), 32'd1);

    // Locked burst: four core cycles to age ext, eight locked beats, then one core cycle.
    beat = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      drive_idle();
      u_if.core_rd   = 1'b1;
      u_if.core_addr = 9'h10;
      u_if.ext_valid = 1'b1;
      u_if.ext_we    = 1'b1;
      u_if.ext_lock  = 1'b1;
      u_if.ext_addr  = 9'(beat * 4);
      u_if.ext_wdata = 32'h100 + 32'(beat);
      #1;
      check($sformatf("burst%0d.ready", c), 32'(u_if.ext_ready),  32'(c >= 4 && c <= 11));
      check($sformatf("burst%0d.stall", c), 32'(u_if.core_stall), 32'(c >= 4 && c <= 11));
      if (u_if.ext_ready) beat++;
    end
    check("burst.beats", 32'(beat), 32'd8);
    @(negedge clk);
    drive_idle();
    #1;
    check("burst.mem00", mem_model[9'h00], 32'h100);
    check("burst.mem1c", mem_model[9'h1C], 32'h107);

    // Asynchronous reset the cycle after an ext read grant drops the pending response.
    @(negedge clk);
    drive_idle();
    u_if.ext_valid = 1'b1;
    u_if.ext_addr  = 9'h20;
    #1;
    check("rstseq.grant", 32'(u_if.ext_ready), 32'd1);
    @(negedge clk);
    reset          = 1'b0;
    u_if.core_rd   = 1'b1;
    u_if.core_addr = 9'h10;
    #1;
    check("rstseq.rvalid", 32'(u_if.ext_rvalid), 32'd0);
    check("rstseq.rdata",  u_if.ext_rdata,       32'd0);
    check("rstseq.ready",  32'(u_if.ext_ready),  32'd0);
    check("rstseq.addr",   32'(u_if.mem_addr),   32'h10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstrel.ready",  32'(u_if.ext_ready),  32'd0);
    check("rstrel.stall",  32'(u_if.core_stall), 32'd0);
    check("rstrel.mem_rd", 32'(u_if.mem_rd),     32'd1);
    check("rstrel.rvalid", 32'(u_if.ext_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
